// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the debounce scan controller.
package debounce_pkg;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} scan_state_e;

    // Event channel field is sized for up to 256 channels; the top truncates to CH_W.
    localparam int EVT_CH_MAX_W = 8;

    typedef struct packed {
        logic [EVT_CH_MAX_W-1:0] ch;
        logic                    level;
    } db_evt_t;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int s);
        return (s < 1) ? 1 : $clog2(s + 1);
    endfunction

endpackage

// File: rtl/db_tick_gen.sv
// Sample-tick prescaler: counts 0..PRESCALE-1 while enabled, pulses tick_o on the last count.
module db_tick_gen #(
    parameter int PRESCALE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int PW = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);

    logic [PW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == PW'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick_o = en_i && w_wrap;

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed switch debouncer: one counter/compare engine visits every channel per sample tick.
// Build option: DEBOUNCE_SCAN_SYNC_EN adds a 2-flop input synchronizer per channel.
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int PRESCALE   = 1000,
    parameter  int STABLE_CNT = 8,
    localparam int CH_W       = ch_w(NUM_CH),
    localparam int CNT_W      = cnt_w(STABLE_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [NUM_CH-1:0] sw_i,
    output logic [NUM_CH-1:0] db_o,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [CH_W-1:0]   evt_ch_o,
    output logic              evt_level_o,
    output logic              ovf_o,
    input  logic              clr_ovf_i,
    output logic              busy_o
);

    if (PRESCALE < NUM_CH + 2) begin : g_bad_prescale
        $error("debounce_scan_ctrl: PRESCALE must be >= NUM_CH+2");
    end

    logic [NUM_CH-1:0] w_sw;

`ifdef DEBOUNCE_SCAN_SYNC_EN
    logic [NUM_CH-1:0] r_sync1, r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_i;
            r_sync2 <= r_sync1;
        end
    end
    assign w_sw = r_sync2;
`else
    assign w_sw = sw_i;
`endif

    logic w_tick;

    db_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_i),
        .tick_o (w_tick)
    );

    scan_state_e                  r_state;
    logic [CH_W-1:0]              r_idx;
    logic [NUM_CH-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_CH-1:0]            r_db;
    db_evt_t                      r_evt;
    logic                         r_evt_valid;
    logic                         r_ovf;

    logic w_visit, w_s, w_diff, w_stable, w_post, w_hs, w_last, w_drop;

    assign w_visit  = (r_state == SCAN);
    assign w_s      = w_sw[r_idx];
    assign w_diff   = (w_s != r_db[r_idx]);
    assign w_stable = (r_cnt[r_idx] == CNT_W'(STABLE_CNT - 1));
    assign w_post   = w_visit && w_diff && w_stable;
    assign w_hs     = r_evt_valid && evt_ready_i;
    assign w_last   = (r_idx == CH_W'(NUM_CH - 1));
    assign w_drop   = w_post && r_evt_valid && !w_hs;

    // A scan always runs to the last channel, even if en_i drops mid-way.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else if (r_state == IDLE) begin
            if (w_tick) begin
                r_state <= SCAN;
                r_idx   <= '0;
            end
        end else if (w_last) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_db  <= '0;
        end else if (w_visit) begin
            if (!w_diff) begin
                r_cnt[r_idx] <= '0;
            end else if (w_stable) begin
                r_cnt[r_idx] <= '0;
                r_db[r_idx]  <= w_s;
            end else begin
                r_cnt[r_idx] <= r_cnt[r_idx] + 1'b1;
            end
        end
    end

    // Single-entry slot: a post may reuse the slot in the cycle it is being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_valid <= 1'b0;
            r_evt       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_post && (!r_evt_valid || w_hs)) begin
                r_evt_valid <= 1'b1;
                r_evt.ch    <= EVT_CH_MAX_W'(r_idx);
                r_evt.level <= w_s;
            end else if (w_hs) begin
                r_evt_valid <= 1'b0;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    logic w_unused_evt_ch;
    assign w_unused_evt_ch = |r_evt.ch;

    assign db_o        = r_db;
    assign evt_valid_o = r_evt_valid;
    assign evt_ch_o    = r_evt.ch[CH_W-1:0];
    assign evt_level_o = r_evt.level;
    assign ovf_o       = r_ovf;
    assign busy_o      = w_visit;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Self-checking bench for debounce_scan_ctrl: per-cycle reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_debounce_scan_ctrl;

    localparam int NUM_CH     = 4;
    localparam int PRESCALE   = 16;
    localparam int STABLE_CNT = 4;
`ifdef DEBOUNCE_SCAN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_i = 1'b0;
    logic       evt_ready_i = 1'b1;
    logic       clr_ovf_i = 1'b0;
    logic [3:0] sw_i = 4'b0;
    logic [3:0] db_o;
    logic       evt_valid_o;
    logic [1:0] evt_ch_o;
    logic       evt_level_o;
    logic       ovf_o;
    logic       busy_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    debounce_scan_ctrl #(
        .NUM_CH     (NUM_CH),
        .PRESCALE   (PRESCALE),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .sw_i        (sw_i),
        .db_o        (db_o),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_ch_o    (evt_ch_o),
        .evt_level_o (evt_level_o),
        .ovf_o       (ovf_o),
        .clr_ovf_i   (clr_ovf_i),
        .busy_o      (busy_o)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: what each output must be, from the debounce rules, updated once per clock.
    int         m_pre, m_pos, m_c;
    int         m_db [4];
    int         m_cnt[4];
    bit         m_ev_v, m_ovf, m_live = 1'b0;
    int         m_ev_ch, m_ev_lvl;
    logic [3:0] m_hist0, m_hist1, m_s;
    bit         m_tick, m_post, m_hs, m_drop;

    always @(posedge clk) begin
        if (rst) begin
            m_pre = 0; m_pos = -1; m_ev_v = 0; m_ovf = 0; m_ev_ch = 0; m_ev_lvl = 0;
            m_hist0 = '0; m_hist1 = '0;
            for (int i = 0; i < 4; i++) begin m_db[i] = 0; m_cnt[i] = 0; end
            m_live = 1'b1;
        end else begin
            m_s    = (SYNC_LAT == 2) ? m_hist1 : sw_i;
            m_hs   = m_ev_v && evt_ready_i;
            m_tick = en_i && (m_pre == PRESCALE - 1);
            m_pre  = (!en_i || m_tick) ? 0 : m_pre + 1;
            m_post = 0;
            m_c    = m_pos;
            if (m_pos >= 0) begin
                if (int'(m_s[m_c]) == m_db[m_c]) m_cnt[m_c] = 0;
                else if (m_cnt[m_c] == STABLE_CNT - 1) begin
                    m_cnt[m_c] = 0; m_db[m_c] = m_s[m_c]; m_post = 1;
                end else m_cnt[m_c]++;
                m_pos = (m_c == NUM_CH - 1) ? -1 : m_c + 1;
            end else if (m_tick) begin
                m_pos = 0;
            end
            m_drop = m_post && m_ev_v && !m_hs;
            if (m_post && !m_drop) begin
                m_ev_v = 1; m_ev_ch = m_c; m_ev_lvl = m_s[m_c];
            end else if (m_hs) m_ev_v = 0;
            if (m_drop) m_ovf = 1;
            else if (clr_ovf_i) m_ovf = 0;
            m_hist1 = m_hist0;
            m_hist0 = sw_i;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cycle_outputs",
                int'({db_o, evt_valid_o, evt_ch_o, evt_level_o, ovf_o, busy_o}),
                int'({m_db[3][0], m_db[2][0], m_db[1][0], m_db[0][0], m_ev_v,
                      2'(m_ev_ch), m_ev_lvl[0], m_ovf, (m_pos >= 0)}));
        end
    end

    // Accepted events seen on the DUT port, for the directed literal checks.
    int ev_ch[$];
    int ev_lvl[$];
    always @(negedge clk) begin
        if (!rst && evt_valid_o && evt_ready_i) begin
            ev_ch.push_back(evt_ch_o);
            ev_lvl.push_back(evt_level_o);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n * PRESCALE) step();
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        int  r1, f1, r2, lat, waited, nev;
        bit  pb, ok;

        // 1: reset, first scan pulse width and tick period
        rst = 1'b1; en_i = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", int'({db_o, evt_valid_o, evt_ch_o, evt_level_o, ovf_o, busy_o}), 0);
        r1 = -1; f1 = -1; r2 = -1; pb = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy_o && !pb) begin
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
            if (!busy_o && pb && r1 >= 0 && f1 < 0) f1 = i;
            pb = busy_o;
        end
        chk("busy_len", f1 - r1, 4);
        chk("busy_period", r2 - r1, 16);

        // 2: clean press and release on ch2
        ev_ch.delete(); ev_lvl.delete();
        step();
        sw_i[2] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 200 && lat < 0; i++) begin
            step();
            if (db_o[2]) lat = i;
        end
        ok = (lat > 3 * PRESCALE) && (lat <= 4 * PRESCALE + NUM_CH + 2 + SYNC_LAT);
        chk("press_latency_in_window", int'(ok), 1);
        ticks(26);
        chk("press_db", db_o, 4'b0100);
        chk("press_evt_count", ev_ch.size(), 1);
        if (ev_ch.size() >= 1) begin
            chk("press_evt_ch", ev_ch[0], 2);
            chk("press_evt_lvl", ev_lvl[0], 1);
        end
        sw_i[2] = 1'b0;
        ticks(8);
        chk("release_db", db_o, 4'b0000);
        chk("release_evt_count", ev_ch.size(), 2);
        if (ev_ch.size() >= 2) begin
            chk("release_evt_ch", ev_ch[1], 2);
            chk("release_evt_lvl", ev_lvl[1], 0);
        end

        // 3: bounce on ch1 never reaches STABLE_CNT consecutive samples
        ev_ch.delete(); ev_lvl.delete();
        for (int i = 0; i < 50; i++) begin
            sw_i[1] = 1'b1;
            ticks($urandom_range(1, 3));
            sw_i[1] = 1'b0;
            ticks($urandom_range(1, 3));
        end
        ticks(3);
        chk("bounce_db", db_o, 4'b0000);
        chk("bounce_evt_count", ev_ch.size(), 0);

        // 4: consumer stalled, two channels switch together
        evt_ready_i = 1'b0;
        sw_i[1:0] = 2'b11;
        ticks(6);
        chk("stall_valid", evt_valid_o, 1);
        chk("stall_ch", evt_ch_o, 0);
        chk("stall_lvl", evt_level_o, 1);
        chk("stall_ovf", ovf_o, 1);
        chk("stall_db", db_o, 4'b0011);
        clr_ovf_i = 1'b1;
        step();
        clr_ovf_i = 1'b0;
        @(negedge clk);
        chk("clr_ovf", ovf_o, 0);
        chk("held_after_clr", int'({evt_valid_o, evt_ch_o, evt_level_o}), 4'b1001);
        step();
        evt_ready_i = 1'b1;
        repeat (3) step();
        chk("drain_count", ev_ch.size(), 1);
        if (ev_ch.size() >= 1) chk("drain_evt", ev_ch[0] * 2 + ev_lvl[0], 1);
        chk("drain_valid", evt_valid_o, 0);

        // 5: reset while scanning, ch3 one sample short of switching
        sw_i[3] = 1'b1;
        waited = 0;
        while (!(m_cnt[3] == 3 && m_pos == 1) && waited < 400) begin
            step();
            waited++;
        end
        chk("mid_scan_reached", int'(waited < 400), 1);
        nev = ev_ch.size();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_scan_reset_outputs", int'({db_o, evt_valid_o, evt_ch_o, evt_level_o, ovf_o, busy_o}), 0);
        chk("mid_scan_no_event", ev_ch.size(), nev);
        ticks(8);
        chk("after_reset_db", db_o, 4'b1011);

        // 6: scan disabled, inputs move, nothing changes
        waited = 0;
        while (!(m_pos < 0 && m_pre == 2) && waited < 100) begin
            step();
            waited++;
        end
        en_i = 1'b0;
        r1 = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 7 == 0) sw_i[0] = ~sw_i[0];
            step();
            if (busy_o) r1++;
        end
        chk("disabled_busy_cycles", r1, 0);
        chk("disabled_db", db_o, 4'b1011);
        en_i = 1'b1;
        sw_i[0] = 1'b0;
        ticks(8);
        chk("resume_db", db_o, 4'b1010);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
